// File: rtl/car_detect_conditioner_pkg.sv
// Shared definitions for the junction: lightseq bit meaning and the legal
// light patterns, so the FSM and the car detector agree on bit positions.
package car_detect_conditioner_pkg;

   typedef logic [5:0] lightseq_t;

   // lightseq bit indices: [5:3] road 1 R,A,G; [2:0] road 2 R,A,G
   localparam int R1_R = 5;
   localparam int R1_A = 4;
   localparam int R1_G = 3;
   localparam int R2_R = 2;
   localparam int R2_A = 1;
   localparam int R2_G = 0;

   // Light patterns driven by the junction FSM
   typedef enum logic [5:0] {
      LS_ALL_RED = 6'b100100,
      LS_G1_R2   = 6'b001100,
      LS_A1_R2   = 6'b010100,
      LS_R1_G2   = 6'b100001,
      LS_R1_A2   = 6'b100010
   } light_pat_e;

endpackage

// File: rtl/car_detect_conditioner_if.sv
// Junction-FSM side bus of the car detector: lights in, requests and
// arrival counts out.
interface car_detect_conditioner_if #(
   parameter int ARR_W = 8
);
   import car_detect_conditioner_pkg::*;

   lightseq_t        lightseq;
   logic             count_clr;
   logic             D1;
   logic             D2;
   logic [ARR_W-1:0] arrivals1;
   logic [ARR_W-1:0] arrivals2;

   modport master (output lightseq, count_clr, input D1, D2, arrivals1, arrivals2);
   modport slave  (input lightseq, count_clr, output D1, D2, arrivals1, arrivals2);

endinterface

// File: rtl/car_detect_conditioner_channel.sv
// One sensor channel: 2-flop synchroniser, counting debouncer, latched
// car-waiting request cleared by own green, saturating arrival counter.
module car_detect_channel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 4,
   parameter int ARR_W           = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             raw_i,
   input  logic             green_i,
   input  logic             count_clr_i,
   output logic             req_o,
   output logic [ARR_W-1:0] arrivals_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, req_d;
   logic [ARR_W-1:0] arr_q, arr_d;
   logic             rise;

   // Debounce: deb flips only after DEBOUNCE_CYCLES consecutive differing samples
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (s2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         deb_d = ~deb_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign rise = ~deb_q & deb_d;

   // Request and arrival next state: green clears first, clear beats increment
   always_comb begin
      req_d = req_q;
      if (green_i)    req_d = 1'b0;
      else if (deb_q) req_d = 1'b1;
      arr_d = arr_q;
      if (count_clr_i)  arr_d = '0;
      else if (rise)    arr_d = (&arr_q) ? arr_q : arr_q + ARR_W'(1);
   end

   // All channel state, cleared asynchronously
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         deb_q <= 1'b0;
         cnt_q <= '0;
         req_q <= 1'b0;
         arr_q <= '0;
      end else begin
         s1_q  <= raw_i;
         s2_q  <= s1_q;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
         req_q <= req_d;
         arr_q <= arr_d;
      end
   end

   assign req_o      = req_q;
   assign arrivals_o = arr_q;

endmodule

// File: rtl/car_detect_conditioner.sv
// Car detector for the junction: two independent sensor channels whose
// requests are cleared by that road's green light.
module car_detect_conditioner
   import car_detect_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 4,
   parameter int ARR_W           = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     sensor1_raw,
   input  logic                     sensor2_raw,
   car_detect_conditioner_if.slave  bus
);

   logic [1:0]            raw, green, req;
   logic [1:0][ARR_W-1:0] arr;
   logic                  unused_light_bits;

   assign raw   = {sensor2_raw, sensor1_raw};
   assign green = {bus.lightseq[R2_G], bus.lightseq[R1_G]};

   // Only the green bits matter to the detector
   assign unused_light_bits = ^{bus.lightseq[R1_R], bus.lightseq[R1_A],
                                bus.lightseq[R2_R], bus.lightseq[R2_A]};

   for (genvar c = 0; c < 2; c++) begin : g_ch
      car_detect_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .ARR_W           (ARR_W)
      ) u_ch (
         .clock       (clock),
         .reset       (reset),
         .raw_i       (raw[c]),
         .green_i     (green[c]),
         .count_clr_i (bus.count_clr),
         .req_o       (req[c]),
         .arrivals_o  (arr[c])
      );
   end

   assign bus.D1        = req[0];
   assign bus.D2        = req[1];
   assign bus.arrivals1 = arr[0];
   assign bus.arrivals2 = arr[1];

endmodule

// File: tb/tb_car_detect_conditioner.sv
// Bench for car_detect_conditioner: directed scenarios plus random traffic,
// checked every cycle against a sample-history reference model.
module tb_car_detect_conditioner;
   import car_detect_conditioner_pkg::*;

   localparam int DC = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic sensor1_raw = 1'b0;
   logic sensor2_raw = 1'b0;

   car_detect_conditioner_if #(.ARR_W(8)) bus();

   car_detect_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(4), .ARR_W(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .sensor1_raw (sensor1_raw),
      .sensor2_raw (sensor2_raw),
      .bus         (bus)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference model: hist[c][0] is the raw value sampled at the latest edge
   bit hist [2][16];
   bit m_deb [2];
   bit m_d   [2];
   int m_arr [2];

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 16; k++) hist[c][k] = 1'b0;
         m_deb[c] = 1'b0;
         m_d[c]   = 1'b0;
         m_arr[c] = 0;
      end
   endtask

   // One clock edge of the spec: deb flips when the last DC synchronised
   // samples (raw delayed by two edges) all differ from it.
   task automatic model_step();
      bit raw, green, all_diff, nd;
      for (int c = 0; c < 2; c++) begin
         raw   = (c == 0) ? sensor1_raw : sensor2_raw;
         green = (c == 0) ? bus.lightseq[R1_G] : bus.lightseq[R2_G];
         all_diff = 1'b1;
         for (int k = 1; k <= DC; k++) if (hist[c][k] == m_deb[c]) all_diff = 1'b0;
         nd = all_diff ? ~m_deb[c] : m_deb[c];
         if (green)         m_d[c] = 1'b0;
         else if (m_deb[c]) m_d[c] = 1'b1;
         if (bus.count_clr)                     m_arr[c] = 0;
         else if (!m_deb[c] && nd && m_arr[c] < 255) m_arr[c]++;
         m_deb[c] = nd;
         for (int k = 15; k > 0; k--) hist[c][k] = hist[c][k-1];
         hist[c][0] = raw;
      end
   endtask

   task automatic check_all();
      chk("D1", int'(bus.D1), int'(m_d[0]));
      chk("D2", int'(bus.D2), int'(m_d[1]));
      chk("arrivals1", int'(bus.arrivals1), m_arr[0]);
      chk("arrivals2", int'(bus.arrivals2), m_arr[1]);
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) model_reset();
      else       model_step();
      #1;
      check_all();
   endtask

   // Ticks until the chosen request rises; n = edge count, 0 if it never does
   task automatic wait_d(input int ch, output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if ((ch == 0) ? bus.D1 : bus.D2) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: total=%0d", total);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [5:0] pats [5];
      logic [6:0] glitch;
      pats[0] = LS_ALL_RED; pats[1] = LS_G1_R2; pats[2] = LS_A1_R2;
      pats[3] = LS_R1_G2;   pats[4] = LS_R1_A2;
      glitch  = 7'b1110111;
      bus.lightseq  = LS_ALL_RED;
      bus.count_clr = 1'b0;
      model_reset();

      // Reset state
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      chk("rst_D1", int'(bus.D1), 0);
      chk("rst_arr1", int'(bus.arrivals1), 0);

      // Road 2 car under road 1 green: latency and arrival count
      bus.lightseq = LS_G1_R2;
      sensor2_raw  = 1'b1;
      wait_d(1, n);
      chk("D2_latency", n, 7);
      chk("arr2_one", int'(bus.arrivals2), 1);
      chk("D1_idle", int'(bus.D1), 0);

      // Short pulses on road 1 never reach the request
      bus.lightseq = LS_ALL_RED;
      sensor1_raw = 1'b1;
      repeat (3) tick();
      sensor1_raw = 1'b0;
      repeat (3) tick();
      for (int i = 6; i >= 0; i--) begin
         sensor1_raw = glitch[i];
         tick();
      end
      sensor1_raw = 1'b0;
      repeat (8) tick();
      chk("D1_glitch", int'(bus.D1), 0);
      chk("arr1_glitch", int'(bus.arrivals1), 0);

      // Own green clears D2 while the car is still there; red re-requests
      bus.lightseq = LS_R1_G2;
      tick();
      chk("D2_green_clr", int'(bus.D2), 0);
      repeat (3) begin
         tick();
         chk("D2_green_hold", int'(bus.D2), 0);
      end
      bus.lightseq = LS_ALL_RED;
      tick();
      chk("D2_rereq", int'(bus.D2), 1);

      // Asynchronous reset in the middle of a debounce
      sensor1_raw = 1'b1;
      repeat (3) tick();
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("async_D2", int'(bus.D2), 0);
      chk("async_arr2", int'(bus.arrivals2), 0);
      sensor1_raw = 1'b0;
      sensor2_raw = 1'b0;
      reset = 1'b0;
      repeat (3) tick();

      // 300 clean arrivals saturate the counter
      bus.lightseq = LS_R1_G2;
      for (int i = 0; i < 300; i++) begin
         sensor1_raw = 1'b1;
         repeat (6) tick();
         sensor1_raw = 1'b0;
         repeat (6) tick();
      end
      chk("arr1_sat", int'(bus.arrivals1), 255);

      // Clear in the same cycle as a new arrival wins
      sensor1_raw = 1'b1;
      repeat (5) tick();
      bus.count_clr = 1'b1;
      tick();
      bus.count_clr = 1'b0;
      chk("clr_wins", int'(bus.arrivals1), 0);
      tick();
      chk("D1_after_clr", int'(bus.D1), 1);

      // Both roads rise together under all-red
      reset = 1'b1;
      sensor1_raw = 1'b0;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      bus.lightseq = LS_ALL_RED;
      sensor1_raw = 1'b1;
      sensor2_raw = 1'b1;
      wait_d(0, n);
      chk("D1_latency", n, 7);
      chk("D2_same_edge", int'(bus.D2), 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(4, 0) == 0) sensor1_raw = ~sensor1_raw;
         if ($urandom_range(4, 0) == 0) sensor2_raw = ~sensor2_raw;
         if ($urandom_range(15, 0) == 0) bus.lightseq = pats[$urandom_range(4, 0)];
         bus.count_clr = ($urandom_range(63, 0) == 0);
         reset = ($urandom_range(499, 0) == 0);
         tick();
      end
      reset = 1'b0;
      bus.count_clr = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
